// File: rtl/ext_pkg.sv
// rtl/ext_pkg.sv - EXTOp encodings shared by the extender stage and the decode controller
package ext_pkg;

  localparam int EXT_OP_W = 2;

  localparam logic [EXT_OP_W-1:0] EXT_ZERO = 2'd0;
  localparam logic [EXT_OP_W-1:0] EXT_SIGN = 2'd1;
  localparam logic [EXT_OP_W-1:0] EXT_LUI  = 2'd2;
  localparam logic [EXT_OP_W-1:0] EXT_SHL2 = 2'd3;

endpackage

// File: rtl/ext_core.sv
// rtl/ext_core.sv - combinational immediate extender, four EXTOp modes
module ext_core
  import ext_pkg::*;
#(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32
) (
  input  logic [IMM_W-1:0]    i_imm,
  input  logic [EXT_OP_W-1:0] i_op,
  output logic [DATA_W-1:0]   o_data
);

  localparam int PAD_W = DATA_W - IMM_W;

  logic [DATA_W-1:0] w_sext;

  assign w_sext = {{PAD_W{i_imm[IMM_W-1]}}, i_imm};

  always_comb begin
    o_data = '0;
    case (i_op)
      EXT_ZERO: o_data = {{PAD_W{1'b0}}, i_imm};
      EXT_SIGN: o_data = w_sext;
      EXT_LUI:  o_data = {i_imm, {PAD_W{1'b0}}};
      EXT_SHL2: o_data = {w_sext[DATA_W-3:0], 2'b00};
      default:  o_data = '0;
    endcase
  end

endmodule

// File: rtl/ext_pipe.sv
// rtl/ext_pipe.sv - buffered immediate-extension stage: extender feeding a DEPTH-entry FIFO
module ext_pipe
  import ext_pkg::*;
#(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 8,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IMM_W-1:0]         in_imm,
  input  logic [EXT_OP_W-1:0]      in_op,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_imm,
  output logic [TAG_W-1:0]         out_tag,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || IMM_W < 1 || IMM_W > DATA_W - 2) begin : g_bad_params
    $error("ext_pipe: illegal DEPTH/IMM_W/DATA_W combination");
  end

  logic [DATA_W-1:0] r_mem_imm [DEPTH];
  logic [TAG_W-1:0]  r_mem_tag [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic [DATA_W-1:0] r_out_imm;
  logic [TAG_W-1:0]  r_out_tag;

  logic [DATA_W-1:0] w_ext;
  logic              w_push;
  logic              w_pop;
  logic [PTR_W-1:0]  w_rd_nxt;
  logic [LVL_W-1:0]  w_level_nxt;

  ext_core #(
    .IMM_W  (IMM_W),
    .DATA_W (DATA_W)
  ) u_core (
    .i_imm  (in_imm),
    .i_op   (in_op),
    .o_data (w_ext)
  );

  assign in_ready  = (r_level < LVL_W'(DEPTH)) & ~flush;
  assign out_valid = (r_level != '0);
  assign out_imm   = r_out_imm;
  assign out_tag   = r_out_tag;
  assign level     = r_level;

  assign w_push   = in_valid & in_ready;
  assign w_pop    = out_valid & out_ready & ~flush;
  assign w_rd_nxt = w_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop) begin
      w_level_nxt = r_level + LVL_W'(1);
    end else if (!w_push && w_pop) begin
      w_level_nxt = r_level - LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_imm[r_wr_ptr] <= w_ext;
      r_mem_tag[r_wr_ptr] <= in_tag;
    end
  end

  // Head register is reloaded from the slot that becomes the head; when the
  // queue drains to empty it is left alone so out_* hold their last value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_out_imm <= '0;
      r_out_tag <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      r_rd_ptr <= w_rd_nxt;
      r_level  <= w_level_nxt;
      if (w_level_nxt != '0) begin
        if (w_push && (w_rd_nxt == r_wr_ptr)) begin
          r_out_imm <= w_ext;
          r_out_tag <= in_tag;
        end else begin
          r_out_imm <= r_mem_imm[w_rd_nxt];
          r_out_tag <= r_mem_tag[w_rd_nxt];
        end
      end
    end
  end

endmodule

// File: tb/tb_ext_pipe.sv
// tb/tb_ext_pipe.sv - directed self-checking bench for ext_pipe (default and 12/24/4 configurations)
module tb_ext_pipe;
  import ext_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [15:0] a_in_imm;
  logic [1:0]  a_in_op;
  logic [7:0]  a_in_tag, a_out_tag;
  logic [31:0] a_out_imm;
  logic [1:0]  a_level;

  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [11:0] b_in_imm;
  logic [1:0]  b_in_op;
  logic [7:0]  b_in_tag, b_out_tag;
  logic [23:0] b_out_imm;
  logic [2:0]  b_level;

  int total = 0;
  int bad   = 0;

  ext_pipe #(.IMM_W(16), .DATA_W(32), .TAG_W(8), .DEPTH(2)) u_dut_a (
    .clk       (clk),
    .reset     (reset),
    .flush     (a_flush),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_imm    (a_in_imm),
    .in_op     (a_in_op),
    .in_tag    (a_in_tag),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_imm   (a_out_imm),
    .out_tag   (a_out_tag),
    .level     (a_level)
  );

  ext_pipe #(.IMM_W(12), .DATA_W(24), .TAG_W(8), .DEPTH(4)) u_dut_b (
    .clk       (clk),
    .reset     (reset),
    .flush     (b_flush),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_imm    (b_in_imm),
    .in_op     (b_in_op),
    .in_tag    (b_in_tag),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_imm   (b_out_imm),
    .out_tag   (b_out_tag),
    .level     (b_level)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp2 [4];

  initial begin
    exp2 = '{32'h00008001, 32'hFFFF8001, 32'h80010000, 32'hFFFE0004};
    reset = 1'b0;
    a_flush = 0; a_in_valid = 0; a_in_imm = '0; a_in_op = '0; a_in_tag = '0; a_out_ready = 0;
    b_flush = 0; b_in_valid = 0; b_in_imm = '0; b_in_op = '0; b_in_tag = '0; b_out_ready = 0;

    #2;
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_level", a_level, 0);
    chk("rst_out_imm", a_out_imm, 0);
    chk("rst_out_tag", a_out_tag, 0);
    chk("rst_b_out_valid", b_out_valid, 0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("rel_in_ready", a_in_ready, 1);
    chk("rel_b_in_ready", b_in_ready, 1);

    // T2: every mode, one cycle latency, output held after drain
    for (int op = 0; op < 4; op++) begin
      a_in_valid = 1; a_in_imm = 16'h8001; a_in_op = 2'(op); a_in_tag = 8'(op); a_out_ready = 1;
      #1;
      chk("t2_no_bypass", a_out_valid, 0);
      tick();
      a_in_valid = 0;
      chk("t2_valid", a_out_valid, 1);
      chk("t2_imm", a_out_imm, exp2[op]);
      chk("t2_tag", a_out_tag, op);
      tick();
      chk("t2_drained", a_level, 0);
      chk("t2_hold_imm", a_out_imm, exp2[op]);
    end

    // T3: fill, refuse third push, stable head, in-order drain
    a_out_ready = 0; a_in_op = EXT_ZERO; a_in_imm = 16'h0005;
    a_in_valid = 1; a_in_tag = 8'd1;
    tick();
    a_in_tag = 8'd2;
    tick();
    a_in_tag = 8'd3;
    chk("t3_level_full", a_level, 2);
    chk("t3_in_ready_full", a_in_ready, 0);
    chk("t3_head", a_out_tag, 1);
    tick();
    chk("t3_refused_level", a_level, 2);
    chk("t3_head_stable", a_out_tag, 1);
    a_in_valid = 0; a_out_ready = 1;
    tick();
    chk("t3_pop2", a_out_tag, 2);
    chk("t3_level1", a_level, 1);
    tick();
    chk("t3_empty", a_out_valid, 0);
    a_out_ready = 0;

    // T4: level 1 with concurrent push/pop across pointer wrap
    a_in_valid = 1; a_in_tag = 8'd100;
    tick();
    a_out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      a_in_tag = 8'(i);
      tick();
      chk("t4_level", a_level, 1);
      chk("t4_tag", a_out_tag, i);
    end
    a_in_valid = 0;
    tick();
    chk("t4_drained", a_level, 0);
    a_out_ready = 0;

    // T5: flush at full with a presented entry, then flush gating in_ready at low level
    a_in_valid = 1; a_in_tag = 8'd20;
    tick();
    a_in_tag = 8'd21;
    tick();
    a_flush = 1; a_in_tag = 8'd22;
    tick();
    a_flush = 0; a_in_valid = 0;
    chk("t5_level", a_level, 0);
    chk("t5_valid", a_out_valid, 0);
    a_out_ready = 1;
    tick();
    chk("t5_nothing_appears", a_out_valid, 0);
    a_flush = 1; a_in_valid = 1; a_in_tag = 8'd22;
    #1;
    chk("t5_flush_in_ready", a_in_ready, 0);
    tick();
    a_flush = 0;
    chk("t5_dropped", a_level, 0);
    a_in_tag = 8'd23;
    tick();
    a_in_valid = 0;
    chk("t5_post_flush_tag", a_out_tag, 23);
    chk("t5_post_flush_level", a_level, 1);
    tick();
    chk("t5_post_flush_drain", a_level, 0);
    a_out_ready = 0;

    // T1: asynchronous reset with two entries queued
    a_in_valid = 1; a_in_imm = 16'h1234; a_in_tag = 8'd30;
    tick();
    a_in_tag = 8'd31;
    tick();
    a_in_valid = 0;
    chk("t1_level_pre", a_level, 2);
    #2;
    reset = 1'b0;
    #1;
    chk("t1_valid", a_out_valid, 0);
    chk("t1_level", a_level, 0);
    chk("t1_imm", a_out_imm, 0);
    chk("t1_tag", a_out_tag, 0);
    tick();
    reset = 1'b1;
    #1;
    chk("t1_in_ready", a_in_ready, 1);

    // T6: 12/24/4 configuration
    b_in_valid = 1; b_in_imm = 12'hFFF; b_in_op = EXT_SIGN; b_in_tag = 8'd1;
    tick();
    chk("t6_sign", b_out_imm, 24'hFFFFFF);
    b_in_imm = 12'h001; b_in_op = EXT_ZERO; b_in_tag = 8'd2;
    tick();
    b_in_tag = 8'd3;
    tick();
    chk("t6_level3", b_level, 3);
    chk("t6_ready3", b_in_ready, 1);
    b_in_tag = 8'd4;
    tick();
    b_in_valid = 0;
    chk("t6_level4", b_level, 4);
    chk("t6_ready4", b_in_ready, 0);
    chk("t6_head", b_out_tag, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
